lpc_wb_mbox_ctrl: RTL
=====================

Name: lpc_wb_mbox_ctrl

Overview:
Sequences LPC host I/O cycles, already synchronized into the Wishbone clock domain, through a single-entry mailbox serviced by the M4 over the FPGA Wishbone slave bus.
- Captures one LPC request and raises FPGA_INTR[0] towards the M4.
- Holds the request until firmware writes a response or a timeout fires.
- Returns the response to the LPC-side logic with a valid/ready handshake.
- Sits inside AL4S3B_FPGA_IP, between the LPC peripheral's CDC stage and the Wishbone register decode.

Parameters:
- TIMEOUT_CYC, 2400, WB_CLK cycles in PEND before an auto-response (30 us at 80 MHz).
- CNT_W, 12, timeout counter width; TIMEOUT_CYC must satisfy TIMEOUT_CYC < 2**CNT_W.

Ports:
- WB_CLK  in  1  Wishbone clock (Sys_Clk0 via gclkbuff); the only clock.
- WB_RST  in  1  asynchronous, active-high reset (WB_RST_FPGA).
- WBs_ADR  in  17  Wishbone address; bits [3:2] select the register.
- WBs_CYC  in  1  block select, already decoded by the parent.
- WBs_STB  in  1  transfer strobe.
- WBs_WE  in  1  write enable.
- WBs_BYTE_STB  in  4  byte enables.
- WBs_WR_DAT  in  32  write data.
- WBs_RD_DAT  out  32  read data.
- WBs_ACK  out  1  transfer acknowledge.
- req_valid  in  1  LPC request present.
- req_ready  out  1  request accepted.
- req_write  in  1  1 = I/O write, 0 = I/O read.
- req_addr  in  16  LPC I/O address.
- req_data  in  8  LPC write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_data  out  8  read data returned to the host.
- rsp_err  out  1  response was produced by timeout.
- mbox_intr  out  1  to FPGA_INTR[0].

Behaviour:
- Reset values: WBs_ACK=0, WBs_RD_DAT=0, rsp_valid=0, rsp_data=0, rsp_err=0, mbox_intr=0, CTRL=0, STATUS=0, state=IDLE. req_ready=1 once in IDLE.
- Register map (word offsets):
  - 0 REQ (RO): {7'b0, dir[24], addr[23:8], data[7:0]}. Reading has no side effect.
  - 1 RSP (WO): byte 0 = response data. Only BYTE_STB[0] is used.
  - 2 STATUS: bit0 pending (RO), bit1 timeout (sticky, write-1-to-clear).
  - 3 CTRL (RW): bit0 intr_en. Other bits read 0.
- Wishbone: WBs_ACK is registered and asserted for 1 cycle, 1 cycle after CYC&STB&!WBs_ACK. Back-to-back transfers therefore take 2 cycles each. WBs_RD_DAT is valid with ACK and is 0 otherwise. Writes take effect on the ACK cycle.
- FSM:
  - IDLE: req_ready=1. On req_valid, capture dir/addr/data, clear the counter, go to PEND.
  - PEND: req_ready=0; mbox_intr = intr_en (registered). The counter increments each cycle.
    - On an RSP write: rsp_data=WR_DAT[7:0], rsp_err=0, go to RESP.
    - When the counter reaches TIMEOUT_CYC-1: rsp_data=8'hFF, rsp_err=1, set STATUS.timeout, go to RESP.
  - RESP: rsp_valid=1, mbox_intr=0, rsp_data/rsp_err held stable. On rsp_ready, rsp_valid drops next cycle and the FSM returns to IDLE.
- Boundary conditions:
  - RSP write outside PEND: ignored, still ACKed.
  - RSP write with BYTE_STB[0]=0: ignored.
  - RSP write and timeout in the same cycle: the firmware write wins (err=0). STATUS.timeout is not set.
  - W1C and timeout-set in the same cycle: set wins.
  - rsp_ready held low: RESP persists indefinitely; req_valid is not accepted.
  - The LPC side must hold the request fields while req_valid=1 and req_ready=0.
  - WB_RST at any time: immediate return to reset values. A pending request is dropped without a response.
  - Clearing intr_en in PEND drops mbox_intr next cycle; the FSM is unaffected.

Optional Feature:
LPC_MBOX_TIMEOUT_EN.
- Defined: timeout counter and auto-response present, as described above.
- Undefined: no counter; PEND waits indefinitely for firmware. STATUS bit1 reads 0 and rsp_err is always 0. TIMEOUT_CYC and CNT_W are unused.

Decomposition:
- Package lpc_mbox_pkg:
  - FSM state encoding (IDLE/PEND/RESP).
  - Register word offsets.
  - STATUS/CTRL bit indices.
  - Timeout fill value 8'hFF.
- One sub-module, lpc_mbox_wb_regs: address decode, ACK generation, read mux, CTRL/STATUS storage, RSP write strobe.
- The FSM and counter stay in the top module.

Test Plan:
- Reset mid-PEND with req 0x0080/0xA5 pending -> all outputs at reset values. Next req_valid accepted in 1 cycle.
- intr_en=1; write req addr 0x0080 data 0xA5 -> mbox_intr=1; WB read offset 0 = 0x010080A5; write RSP 0x00 -> rsp_valid with err=0; rsp_ready -> IDLE, mbox_intr=0.
- Read req addr 0x0060; firmware writes RSP 0x0000003C -> rsp_data=0x3C, rsp_err=0. Hold rsp_ready=0 for 10 cycles -> rsp_valid and data stable, req_ready=0.
- TIMEOUT_CYC=16, macro defined, no firmware response -> rsp_valid 16 cycles after capture with rsp_data=0xFF, rsp_err=1, STATUS=0x2. Write 0x2 to STATUS -> reads 0x0.
- RSP write ACK coinciding with the timeout cycle -> rsp_data = firmware value, rsp_err=0, STATUS.timeout=0.
- Macro undefined, no response for 10000 cycles -> remains PEND, STATUS=0x1, rsp_valid=0.

Source files
------------

// File: rtl/lpc_mbox_pkg.sv
// lpc_mbox_pkg: shared definitions for the LPC-to-Wishbone mailbox.
//   - FSM state encoding (IDLE / PEND / RESP)
//   - Wishbone register word offsets (selected by WBs_ADR[3:2])
//   - STATUS / CTRL bit indices
//   - fill value returned to the host on a timeout auto-response
//   - helper that packs a captured request into the REQ register word
package lpc_mbox_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_RESP = 2'd2
    } mbox_state_e;

    localparam logic [1:0] OFF_REQ    = 2'd0;
    localparam logic [1:0] OFF_RSP    = 2'd1;
    localparam logic [1:0] OFF_STATUS = 2'd2;
    localparam logic [1:0] OFF_CTRL   = 2'd3;

    localparam int STAT_PEND_BIT    = 0;
    localparam int STAT_TMO_BIT     = 1;
    localparam int CTRL_INTR_EN_BIT = 0;

    localparam logic [7:0] TMO_FILL = 8'hFF;

    // REQ register layout: {7'b0, dir, addr[15:0], data[7:0]}
    function automatic logic [31:0] pack_req(input logic dir, input logic [15:0] addr,
                                             input logic [7:0] data);
        return {7'd0, dir, addr, data};
    endfunction

endpackage

// File: rtl/lpc_mbox_wb_regs.sv
// lpc_mbox_wb_regs: Wishbone slave register block of the LPC mailbox.
// Decodes WBs_ADR[3:2], generates a one-cycle registered ACK, drives the read
// mux (zero outside ACK), stores CTRL.intr_en and the sticky STATUS.timeout
// bit, and emits a one-cycle strobe when firmware writes the RSP register.
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   wb_*_i / wb_*_o      Wishbone slave signals
//   req_word_i           packed captured request (REQ register contents)
//   pending_i            FSM is in PEND (STATUS bit0)
//   tmo_set_i            timeout fired this cycle (sets STATUS bit1)
//   rsp_wr_o, rsp_wdat_o RSP write strobe and its byte-0 data
//   intr_en_o            CTRL.intr_en
module lpc_mbox_wb_regs
    import lpc_mbox_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [16:0] wb_adr_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_be_i,
    input  logic [31:0] wb_wdat_i,
    output logic [31:0] wb_rdat_o,
    output logic        wb_ack_o,
    input  logic [31:0] req_word_i,
    input  logic        pending_i,
    input  logic        tmo_set_i,
    output logic        rsp_wr_o,
    output logic [7:0]  rsp_wdat_o,
    output logic        intr_en_o
);

    logic        ack_q;
    logic [31:0] rd_dat_q;
    logic        intr_en_q;
    logic        tmo_q;
    logic        req_s;
    logic        wr_s;
    logic [1:0]  off_s;
    logic [31:0] rd_mux_s;
    logic        unused_s;

    assign off_s = wb_adr_i[3:2];
    assign req_s = wb_cyc_i && wb_stb_i && !ack_q;
    // Writes commit at the end of the ACK cycle, when the master samples ACK.
    assign wr_s  = ack_q && wb_cyc_i && wb_stb_i && wb_we_i;

    // Read mux over the four register words
    always_comb begin
        rd_mux_s = 32'd0;
        case (off_s)
            OFF_REQ:    rd_mux_s = req_word_i;
            OFF_RSP:    rd_mux_s = 32'd0;
            OFF_STATUS: rd_mux_s = {30'd0, tmo_q, pending_i};
            OFF_CTRL:   rd_mux_s = {31'd0, intr_en_q};
            default:    rd_mux_s = 32'd0;
        endcase
    end

    // ACK and read-data registers; read data is zero whenever ACK is low
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_q    <= 1'b0;
            rd_dat_q <= 32'd0;
        end else begin
            ack_q    <= req_s;
            rd_dat_q <= (req_s && !wb_we_i) ? rd_mux_s : 32'd0;
        end
    end

    // CTRL.intr_en storage
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            intr_en_q <= 1'b0;
        end else if (wr_s && (off_s == OFF_CTRL) && wb_be_i[0]) begin
            intr_en_q <= wb_wdat_i[CTRL_INTR_EN_BIT];
        end else begin
            intr_en_q <= intr_en_q;
        end
    end

    // STATUS.timeout: sticky, W1C; a coincident set beats the clear
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_q <= 1'b0;
        end else if (tmo_set_i) begin
            tmo_q <= 1'b1;
        end else if (wr_s && (off_s == OFF_STATUS) && wb_be_i[0] && wb_wdat_i[STAT_TMO_BIT]) begin
            tmo_q <= 1'b0;
        end else begin
            tmo_q <= tmo_q;
        end
    end

    assign rsp_wr_o   = wr_s && (off_s == OFF_RSP) && wb_be_i[0];
    assign rsp_wdat_o = wb_wdat_i[7:0];
    assign intr_en_o  = intr_en_q;
    assign wb_rdat_o  = rd_dat_q;
    assign wb_ack_o   = ack_q;
    assign unused_s   = ^{wb_adr_i[16:4], wb_adr_i[1:0], wb_be_i[3:1], wb_wdat_i[31:8]};

endmodule

// File: rtl/lpc_wb_mbox_ctrl.sv
// lpc_wb_mbox_ctrl: single-entry mailbox between the synchronized LPC I/O
// request stream and the M4 firmware on the FPGA Wishbone slave bus.
// IDLE captures a request, PEND raises mbox_intr (if enabled) until firmware
// writes RSP or the timeout fires, RESP presents the response until consumed.
// Optional build macro LPC_MBOX_TIMEOUT_EN: when defined, a TIMEOUT_CYC
// counter auto-responds with 8'hFF / rsp_err=1; when undefined, PEND waits
// for firmware indefinitely.
// Ports:
//   WB_CLK, WB_RST                     clock, asynchronous active-high reset
//   WBs_*                              Wishbone slave (ADR[3:2] selects register)
//   req_valid/req_ready/req_*          LPC request handshake and fields
//   rsp_valid/rsp_ready/rsp_data/err   LPC response handshake and fields
//   mbox_intr                          interrupt to FPGA_INTR[0]
module lpc_wb_mbox_ctrl
    import lpc_mbox_pkg::*;
#(
    parameter int TIMEOUT_CYC = 2400,
    parameter int CNT_W       = 12
) (
    input  logic        WB_CLK,
    input  logic        WB_RST,
    input  logic [16:0] WBs_ADR,
    input  logic        WBs_CYC,
    input  logic        WBs_STB,
    input  logic        WBs_WE,
    input  logic [3:0]  WBs_BYTE_STB,
    input  logic [31:0] WBs_WR_DAT,
    output logic [31:0] WBs_RD_DAT,
    output logic        WBs_ACK,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_data,
    output logic        rsp_err,
    output logic        mbox_intr
);

    mbox_state_e state_q, state_d;
    logic        dir_q;
    logic [15:0] addr_q;
    logic [7:0]  data_q;
    logic [7:0]  rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        mbox_intr_q, mbox_intr_d;
    logic        tmo_set_s;
    logic        tmo_hit_s;
    logic        rsp_wr_s;
    logic [7:0]  rsp_wdat_s;
    logic        intr_en_s;

    lpc_mbox_wb_regs u_regs (
        .clk_i      (WB_CLK),
        .rst_i      (WB_RST),
        .wb_adr_i   (WBs_ADR),
        .wb_cyc_i   (WBs_CYC),
        .wb_stb_i   (WBs_STB),
        .wb_we_i    (WBs_WE),
        .wb_be_i    (WBs_BYTE_STB),
        .wb_wdat_i  (WBs_WR_DAT),
        .wb_rdat_o  (WBs_RD_DAT),
        .wb_ack_o   (WBs_ACK),
        .req_word_i (pack_req(dir_q, addr_q, data_q)),
        .pending_i  (state_q == ST_PEND),
        .tmo_set_i  (tmo_set_s),
        .rsp_wr_o   (rsp_wr_s),
        .rsp_wdat_o (rsp_wdat_s),
        .intr_en_o  (intr_en_s)
    );

`ifdef LPC_MBOX_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign cnt_d     = (state_q == ST_PEND) ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : {CNT_W{1'b0}};
    assign tmo_hit_s = (state_q == ST_PEND) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    // PEND-cycle counter; sits at zero outside PEND so capture starts it at 0
    always_ff @(posedge WB_CLK or posedge WB_RST) begin
        if (WB_RST) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic [CNT_W-1:0] unused_tmo_cfg_s;

    assign unused_tmo_cfg_s = CNT_W'(TIMEOUT_CYC);
    assign tmo_hit_s        = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge WB_CLK or posedge WB_RST) begin
        if (WB_RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; a firmware RSP write outranks a same-cycle timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_valid) state_d = ST_PEND; else state_d = ST_IDLE;
            ST_PEND: if (rsp_wr_s || tmo_hit_s) state_d = ST_RESP; else state_d = ST_PEND;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE; else state_d = ST_RESP;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM output logic: next values of the registered LPC-side outputs
    always_comb begin
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        tmo_set_s  = 1'b0;
        if (state_q == ST_PEND && rsp_wr_s) begin
            rsp_data_d = rsp_wdat_s;
            rsp_err_d  = 1'b0;
        end else if (state_q == ST_PEND && tmo_hit_s) begin
            rsp_data_d = TMO_FILL;
            rsp_err_d  = 1'b1;
            tmo_set_s  = 1'b1;
        end else begin
            rsp_data_d = rsp_data_q;
            rsp_err_d  = rsp_err_q;
        end
        rsp_valid_d = (state_d == ST_RESP);
        mbox_intr_d = (state_d == ST_PEND) && intr_en_s;
    end

    // Registered outputs and request capture
    always_ff @(posedge WB_CLK or posedge WB_RST) begin
        if (WB_RST) begin
            rsp_data_q  <= 8'd0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            mbox_intr_q <= 1'b0;
            dir_q       <= 1'b0;
            addr_q      <= 16'd0;
            data_q      <= 8'd0;
        end else begin
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            rsp_valid_q <= rsp_valid_d;
            mbox_intr_q <= mbox_intr_d;
            if (state_q == ST_IDLE && req_valid) begin
                dir_q  <= req_write;
                addr_q <= req_addr;
                data_q <= req_data;
            end else begin
                dir_q  <= dir_q;
                addr_q <= addr_q;
                data_q <= data_q;
            end
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign mbox_intr = mbox_intr_q;

endmodule
